rv32i_lsu: RTL and testbench
============================

# rv32i_lsu

Parametrised load/store unit with its own byte-addressed data memory for the RV32I core family. It replaces a single-cycle, word-indexed data array with a handshaked, multi-cycle unit.

- Wait states, memory depth and base address are configurable.
- Sub-word accesses use correct byte-lane selection.
- Misaligned, out-of-range and illegal-size accesses are detected and reported.

The unit sits between the core's execute stage and data storage. It also drives the retire/trace memory outputs.

## Interface
Parameters:
- DEPTH_WORDS, 2048: memory size in 32-bit words; power of two, ≥ 4.
- WAIT_CYCLES, 0: extra cycles between acceptance and response, 0..15.
- BASE_ADDR, 32'h8000_0000: byte address of word 0; must be DEPTH_WORDS*4 aligned.

Ports:
- clk_i  in  1  clock, rising edge.
- rstn_i  in  1  reset; one clock; reset is synchronous and active-low.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  unit can accept a request this cycle.
- req_we_i  in  1  1 = store, 0 = load.
- req_funct3_i  in  3  RV32I funct3 (access size and signedness).
- req_addr_i  in  XLEN  byte address.
- req_wdata_i  in  XLEN  store data; only the low bytes for the access size are used.
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_rdata_o  out  XLEN  extended load data; 0 for stores and errors.
- rsp_err_o  out  1  access faulted; qualified by rsp_valid_o.
- mem_addr_o  out  XLEN  retired store byte address; 0 otherwise.
- mem_data_o  out  XLEN  retired store data, zero-extended to the access size; 0 otherwise.
- dbg_addr_i  in  $clog2(DEPTH_WORDS)  debug word index.
- dbg_data_o  out  XLEN  combinational read of the word at dbg_addr_i.

## Operation
- FSM states:
  - IDLE: req_ready_o = 1.
  - WAIT: counts down WAIT_CYCLES.
  - RESP: rsp_valid_o = 1.
- Transitions:
  - IDLE→WAIT on accept when WAIT_CYCLES > 0; IDLE→RESP on accept when WAIT_CYCLES = 0.
  - WAIT→RESP when the counter reaches 0.
  - RESP→IDLE unconditionally.
- Accept: req_valid_i && req_ready_o at a rising edge. The request is latched at that edge, and the inputs may change afterwards.
- Address: offset = addr − BASE_ADDR.
  - Word index = offset[$clog2(DEPTH_WORDS)+1:2].
  - Lane = offset[1:0].
- Loads:
  - LB/LBU: byte at the lane.
  - LH/LHU: half at lane[1].
  - LW: full word.
  - Signed loads sign-extend; unsigned loads zero-extend.
- Stores:
  - SB writes only byte lane; SH writes only half lane[1]; SW writes the full word.
  - Other bytes of the word are preserved.
- Errors (rsp_err_o = 1, no write, rsp_rdata_o = 0, mem_addr_o/mem_data_o = 0):
  - Misaligned: H with lane[0] = 1, or W with lane ≠ 0.
  - Out of range: offset ≥ DEPTH_WORDS*4, including addresses below BASE_ADDR via unsigned wrap.
  - Illegal funct3: load 011/110/111; store ≥ 011.
- mem_addr_o and mem_data_o are non-zero only during rsp_valid_o of a successful store.
- rsp_rdata_o, rsp_err_o, mem_addr_o and mem_data_o are 0 whenever rsp_valid_o = 0.

## Timing
- Reset, when rstn_i is low at an edge:
  - FSM → IDLE; counter → 0; all memory words → 0.
  - rsp_valid_o, rsp_err_o, rsp_rdata_o, mem_addr_o and mem_data_o all read 0.
  - req_ready_o = 1 from the cycle after the reset edge.
  - Requests presented while rstn_i is low are ignored.
- Reset mid-operation: an in-flight request is dropped, with no response and no memory write.
- Latency: accept at edge E; rsp_valid_o is high for exactly one cycle, the cycle after edge E+WAIT_CYCLES.
- req_ready_o is low from the cycle after E until RESP exits. Throughput is one request per WAIT_CYCLES+2 cycles.
- Memory write timing: the store writes at the edge that enters RESP. A load accepted afterwards sees the new value.
- Debug read: dbg_data_o is combinational. It reflects the write in the cycle after that edge.
- Load timing: load data is read at the edge entering RESP and is held in a register during RESP.

## Structure
- riscv_pkg holds:
  - lsu_state_e (IDLE, WAIT, RESP);
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - XLEN.
- Sub-module lsu_align is combinational:
  - load side: lane extract plus sign/zero extend;
  - store side: byte-enable mask plus lane-shifted write data;
  - misalignment/illegal-size check.
- Top level: FSM, counter, request latch, memory array, range check.

## Test plan
- Reset, then SW 0xDEADBEEF @0x8000_0010 -> rsp_err_o = 0, mem_addr_o = 0x8000_0010, mem_data_o = 0xDEADBEEF. Then LW @0x8000_0010 -> 0xDEADBEEF.
- SB 0x7F @0x8000_0011 over 0xDEADBEEF -> word = 0xDEAD7FEF. LB @0x8000_0013 -> 0xFFFFFFDE. LBU @0x8000_0013 -> 0x000000DE.
- SH 0x8001 @0x8000_0022 -> LH @0x8000_0022 = 0xFFFF8001, LHU = 0x00008001. Also dbg_addr_i = 8 gives dbg_data_o = 0x80010000.
- LW @0x8000_0002, SH @0x8000_0001, LW @0x7FFF_FFFC, LW @BASE+DEPTH_WORDS*4, and funct3 = 011 -> each gives rsp_err_o = 1 and rsp_rdata_o = 0, with memory unchanged.
- WAIT_CYCLES = 3, req_valid_i held high -> rsp_valid_o exactly 4 cycles after accept, req_ready_o low for 4 cycles, next accept 5 cycles after the first.
- Assert rstn_i low during WAIT of an SW -> no rsp_valid_o, memory reads 0, req_ready_o = 1 the cycle after the reset edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RV32I load/store path.
// Imported by the LSU top and its alignment helper.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for loads and stores, plus the size/alignment check.
// Purely combinational; the top decides when results are used.
module lsu_align
    import riscv_pkg::*;
(
    input  logic            we,
    input  logic [2:0]      funct3,
    input  logic [1:0]      lane,
    input  logic [XLEN-1:0] wdata,
    input  logic [XLEN-1:0] rword,
    output logic [XLEN-1:0] rdata,
    output logic [3:0]      be,
    output logic [XLEN-1:0] wshift,
    output logic [XLEN-1:0] sdata,
    output logic            bad
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    assign byte_v = rword[{lane, 3'b000} +: 8];
    assign half_v = lane[1] ? rword[31:16] : rword[15:0];

    always_comb begin
        rdata  = '0;
        be     = '0;
        wshift = '0;
        sdata  = '0;
        bad    = 1'b0;
        unique case (funct3)
            F3_B: begin
                rdata  = {{24{byte_v[7]}}, byte_v};
                be     = 4'b0001 << lane;
                wshift = {4{wdata[7:0]}};
                sdata  = {24'b0, wdata[7:0]};
            end
            F3_BU: begin
                rdata = {24'b0, byte_v};
                bad   = we;
            end
            F3_H: begin
                rdata  = {{16{half_v[15]}}, half_v};
                be     = lane[1] ? 4'b1100 : 4'b0011;
                wshift = {2{wdata[15:0]}};
                sdata  = {16'b0, wdata[15:0]};
                bad    = lane[0];
            end
            F3_HU: begin
                rdata = {16'b0, half_v};
                bad   = we | lane[0];
            end
            F3_W: begin
                rdata  = rword;
                be     = 4'b1111;
                wshift = wdata;
                sdata  = wdata;
                bad    = |lane;
            end
            default: bad = 1'b1;
        endcase
    end

endmodule

// File: rtl/rv32i_lsu.sv
// Handshaked multi-cycle load/store unit with private byte-addressed memory.
// FSM, wait counter, request latch, memory array and range check.
module rv32i_lsu
    import riscv_pkg::*;
#(
    parameter int          DEPTH_WORDS = 2048,
    parameter int          WAIT_CYCLES = 0,
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000
) (
    input  logic                           clk_i,
    input  logic                           rstn_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [2:0]                     req_funct3_i,
    input  logic [XLEN-1:0]                req_addr_i,
    input  logic [XLEN-1:0]                req_wdata_i,
    output logic                           rsp_valid_o,
    output logic [XLEN-1:0]                rsp_rdata_o,
    output logic                           rsp_err_o,
    output logic [XLEN-1:0]                mem_addr_o,
    output logic [XLEN-1:0]                mem_data_o,
    input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr_i,
    output logic [XLEN-1:0]                dbg_data_o
);

    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WC = 4'(WAIT_CYCLES);

    logic [XLEN-1:0] mem [DEPTH_WORDS];

    lsu_state_e      state;
    logic [3:0]      cnt;
    logic            q_we;
    logic [2:0]      q_f3;
    logic [XLEN-1:0] q_addr;
    logic [XLEN-1:0] q_wdata;
    logic [XLEN-1:0] rdata_q;
    logic            err_q;
    logic [XLEN-1:0] maddr_q;
    logic [XLEN-1:0] mdata_q;

    logic            accept;
    logic            finish;
    logic            c_we;
    logic [2:0]      c_f3;
    logic [XLEN-1:0] c_addr;
    logic [XLEN-1:0] c_wdata;
    logic [XLEN-1:0] offset;
    logic [AW-1:0]   idx;
    logic            oor;
    logic            err;
    logic [XLEN-1:0] ld_data;
    logic [3:0]      be;
    logic [XLEN-1:0] wshift;
    logic [XLEN-1:0] sdata;
    logic            bad;

    assign req_ready_o = (state == IDLE);
    assign rsp_valid_o = (state == RESP);
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;
    assign mem_addr_o  = maddr_q;
    assign mem_data_o  = mdata_q;
    assign dbg_data_o  = mem[dbg_addr_i];

    assign accept = req_valid_i && req_ready_o;
    assign finish = (accept && WAIT_CYCLES == 0)
                 || (state == WAIT && cnt == 4'd0);

    // With no wait states the request completes on its own accept edge
    assign c_we    = (state == IDLE) ? req_we_i     : q_we;
    assign c_f3    = (state == IDLE) ? req_funct3_i : q_f3;
    assign c_addr  = (state == IDLE) ? req_addr_i   : q_addr;
    assign c_wdata = (state == IDLE) ? req_wdata_i  : q_wdata;

    assign offset = c_addr - BASE_ADDR;
    assign idx    = offset[AW+1:2];
    assign oor    = |offset[XLEN-1:AW+2];
    assign err    = bad | oor;

    lsu_align u_align (
        .we     (c_we),
        .funct3 (c_f3),
        .lane   (offset[1:0]),
        .wdata  (c_wdata),
        .rword  (mem[idx]),
        .rdata  (ld_data),
        .be     (be),
        .wshift (wshift),
        .sdata  (sdata),
        .bad    (bad)
    );

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state   <= IDLE;
            cnt     <= '0;
            q_we    <= 1'b0;
            q_f3    <= '0;
            q_addr  <= '0;
            q_wdata <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            maddr_q <= '0;
            mdata_q <= '0;
            for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
        end else begin
            unique case (state)
                IDLE: if (accept) begin
                    q_we    <= req_we_i;
                    q_f3    <= req_funct3_i;
                    q_addr  <= req_addr_i;
                    q_wdata <= req_wdata_i;
                    if (WAIT_CYCLES == 0) begin
                        state <= RESP;
                    end else begin
                        state <= WAIT;
                        cnt   <= WC - 4'd1;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) state <= RESP;
                    else cnt <= cnt - 4'd1;
                end
                RESP: begin
                    state   <= IDLE;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    maddr_q <= '0;
                    mdata_q <= '0;
                end
                default: state <= IDLE;
            endcase
            if (finish) begin
                err_q   <= err;
                rdata_q <= (err || c_we) ? '0 : ld_data;
                if (!err && c_we) begin
                    maddr_q <= c_addr;
                    mdata_q <= sdata;
                    for (int b = 0; b < 4; b++)
                        if (be[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_rv32i_lsu.sv
// Randomized bench for rv32i_lsu against a byte-array reference model.
// Uses WAIT_CYCLES = 3 and a 64-word memory.
module tb_rv32i_lsu;

    localparam int          DEPTH = 64;
    localparam int          WAITC = 3;
    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          NB    = DEPTH * 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_f3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [5:0]  dbg_addr;
    logic [31:0] dbg_data;

    int n_chk  = 0;
    int n_pass = 0;

    logic [7:0] mm [NB];

    always #5 clk = ~clk;

    rv32i_lsu #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_we_i     (req_we),
        .req_funct3_i (req_f3),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .rsp_valid_o  (rsp_valid),
        .rsp_rdata_o  (rsp_rdata),
        .rsp_err_o    (rsp_err),
        .mem_addr_o   (mem_addr),
        .mem_data_o   (mem_data),
        .dbg_addr_i   (dbg_addr),
        .dbg_data_o   (dbg_data)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] model_word(input int w);
        return {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]};
    endfunction

    // Reference behaviour from size/offset arithmetic on a byte array
    task automatic model_txn(input logic we, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wd,
                             output logic [31:0] e_rd, output logic e_err,
                             output logic [31:0] e_ma, output logic [31:0] e_md);
        logic [31:0] off;
        logic [31:0] v;
        int size;
        logic ill;
        off = addr - BASE;
        case (f3[1:0])
            2'd0: size = 1;
            2'd1: size = 2;
            2'd2: size = 4;
            default: size = 0;
        endcase
        ill = (size == 0) || (f3 == 3'b110) || (we && f3[2]);
        e_err = ill || (off >= NB) || (!ill && (off % size) != 0);
        e_rd = 0; e_ma = 0; e_md = 0;
        if (!e_err) begin
            if (we) begin
                for (int i = 0; i < size; i++) mm[off+i] = wd[8*i +: 8];
                e_ma = addr;
                e_md = (size == 4) ? wd : (wd & ((32'd1 << (8*size)) - 1));
            end else begin
                v = 0;
                for (int i = 0; i < size; i++)
                    v = v | (32'(mm[off+i]) << (8*i));
                if (!f3[2] && size < 4 && v[8*size-1])
                    v = v | (32'hFFFF_FFFF << (8*size));
                e_rd = v;
            end
        end
    endtask

    task automatic mem_scan(input string tag);
        int nbad = 0;
        for (int w = 0; w < DEPTH; w++) begin
            dbg_addr = 6'(w);
            #1;
            if (dbg_data !== model_word(w)) nbad++;
        end
        check(tag, nbad, 0);
    endtask

    task automatic txn(input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd);
        logic [31:0] e_rd, e_ma, e_md;
        logic e_err;
        int t = 0;
        int n = 1;
        @(negedge clk);
        req_valid = 1; req_we = we; req_f3 = f3;
        req_addr = addr; req_wdata = wd;
        while (!req_ready && t < 20) begin @(negedge clk); t++; end
        if (t >= 20) begin check("accept_timeout", 0, 1); rd = 0; return; end
        @(negedge clk);
        req_valid = 0; req_we = $urandom; req_f3 = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        check("idle_zero", {rsp_rdata | mem_addr | mem_data} | 32'(rsp_err), 0);
        while (!rsp_valid && n < 20) begin
            check("ready_busy", 32'(req_ready), 0);
            @(negedge clk); n++;
        end
        check("latency", n, WAITC + 1);
        model_txn(we, f3, addr, wd, e_rd, e_err, e_ma, e_md);
        rd = rsp_rdata;
        check("ready_resp", 32'(req_ready), 0);
        check("rdata", rsp_rdata, e_rd);
        check("err", 32'(rsp_err), 32'(e_err));
        check("mem_addr", mem_addr, e_ma);
        check("mem_data", mem_data, e_md);
        @(negedge clk);
        check("pulse", 32'(rsp_valid), 0);
        check("ready_back", 32'(req_ready), 1);
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] a;
        int acc [2];
        int nacc, trsp;
        rstn = 0; req_valid = 1; req_we = 1; req_f3 = 3'b010;
        req_addr = BASE; req_wdata = 32'h1111_1111; dbg_addr = 0;
        for (int i = 0; i < NB; i++) mm[i] = 0;
        repeat (3) @(negedge clk);
        check("rst_valid", 32'(rsp_valid), 0);
        check("rst_outs", rsp_rdata | mem_addr | mem_data | 32'(rsp_err), 0);
        check("rst_ready", 32'(req_ready), 1);
        rstn = 1; req_valid = 0;
        mem_scan("rst_mem");

        txn(1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, rd);
        txn(0, 3'b010, 32'h8000_0010, 0, rd);
        check("lw_beef", rd, 32'hDEAD_BEEF);
        txn(1, 3'b000, 32'h8000_0011, 32'h1234_567F, rd);
        dbg_addr = 6'd4; #1;
        check("sb_word", dbg_data, 32'hDEAD_7FEF);
        txn(0, 3'b000, 32'h8000_0013, 0, rd);
        check("lb_de", rd, 32'hFFFF_FFDE);
        txn(0, 3'b100, 32'h8000_0013, 0, rd);
        check("lbu_de", rd, 32'h0000_00DE);
        txn(1, 3'b001, 32'h8000_0022, 32'hAAAA_8001, rd);
        txn(0, 3'b001, 32'h8000_0022, 0, rd);
        check("lh_8001", rd, 32'hFFFF_8001);
        txn(0, 3'b101, 32'h8000_0022, 0, rd);
        check("lhu_8001", rd, 32'h0000_8001);
        dbg_addr = 6'd8; #1;
        check("dbg_8", dbg_data, 32'h8001_0000);

        txn(0, 3'b010, 32'h8000_0002, 0, rd);
        txn(1, 3'b001, 32'h8000_0001, 32'hFFFF, rd);
        txn(0, 3'b010, 32'h7FFF_FFFC, 0, rd);
        txn(0, 3'b010, BASE + NB, 0, rd);
        txn(0, 3'b011, 32'h8000_0010, 0, rd);
        txn(1, 3'b011, 32'h8000_0010, 32'h5555_5555, rd);
        mem_scan("err_mem");

        for (int k = 0; k < 200; k++) begin
            int r = $urandom_range(0, 9);
            if (r == 0) a = $urandom;
            else if (r == 1) a = BASE + NB + $urandom_range(0, 64);
            else a = BASE + $urandom_range(0, NB - 1);
            if (r > 1 && r < 7) a = a & ~32'd3;
            txn($urandom_range(0, 1) == 1, 3'($urandom), a, $urandom, rd);
            dbg_addr = 6'($urandom); #1;
            check("dbg_rand", dbg_data, model_word(int'(dbg_addr)));
        end
        mem_scan("rand_mem");

        @(negedge clk);
        req_valid = 1; req_we = 0; req_f3 = 3'b010; req_addr = BASE;
        nacc = 0; trsp = -1;
        for (int c = 0; c < 40 && nacc < 2; c++) begin
            if (rsp_valid && trsp < 0) trsp = c;
            if (req_ready && req_valid) begin acc[nacc] = c; nacc++; end
            @(negedge clk);
        end
        req_valid = 0;
        check("tp_accepts", nacc, 2);
        if (nacc == 2) begin
            check("tp_gap", acc[1] - acc[0], WAITC + 2);
            check("tp_lat", trsp - acc[0], WAITC + 1);
        end
        repeat (8) @(negedge clk);

        req_valid = 1; req_we = 1; req_f3 = 3'b010;
        req_addr = BASE + 32'h10; req_wdata = 32'h1234_5678;
        while (!req_ready) @(negedge clk);
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        rstn = 0;
        @(negedge clk);
        rstn = 1;
        check("mid_ready", 32'(req_ready), 1);
        for (int i = 0; i < NB; i++) mm[i] = 0;
        trsp = 0;
        for (int c = 0; c < 8; c++) begin
            if (rsp_valid) trsp++;
            @(negedge clk);
        end
        check("mid_no_rsp", trsp, 0);
        mem_scan("mid_mem");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
